// File: rtl/riscv_ifetch_if.sv
// Fetch-stage bundle: PC control, instruction-memory read port, decoder handshake
// and branch/jump redirect. master = fetch unit, slave = surrounding pipeline.
interface riscv_ifetch_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] pc_value;
    logic              pc_en;
    logic              pc_src;
    logic [31:0]       pc_target;
    logic              imem_rd;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              redirect;
    logic [31:0]       redirect_addr;

    modport master (
        input  pc_value, imem_rdata, instr_ready, redirect, redirect_addr,
        output pc_en, pc_src, pc_target, imem_rd, imem_addr,
        instr, instr_pc, instr_valid
    );

    modport slave (
        output pc_value, imem_rdata, instr_ready, redirect, redirect_addr,
        input  pc_en, pc_src, pc_target, imem_rd, imem_addr,
        instr, instr_pc, instr_valid
    );
endinterface

// File: rtl/riscv_ifetch.sv
// Instruction-fetch stage: steps the PC, reads the synchronous instruction memory
// and holds each fetched word for the decoder under a valid/ready handshake.
module riscv_ifetch #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] RESET_VEC = 32'h0,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    riscv_ifetch_if.master        bus
);
    typedef enum logic [1:0] {S_BOOT, S_ISSUE, S_WAIT, S_HOLD} state_t;

    state_t            state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;

    logic              pc_en, pc_src, imem_rd;
    logic [31:0]       pc_target;
    logic [ADDR_W-1:0] imem_addr;

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        req_pc_d   = req_pc_q;
        pc_en      = 1'b0;
        pc_src     = 1'b0;
        pc_target  = 32'h0;
        imem_rd    = 1'b0;
        imem_addr  = '0;

        if (!rst) begin
            imem_addr = bus.pc_value;
            if (state_q == S_BOOT) begin
                // A redirect during BOOT is ignored: the reset vector must win.
                pc_en     = 1'b1;
                pc_src    = 1'b1;
                pc_target = RESET_VEC;
                state_d   = S_ISSUE;
            end else if (bus.redirect) begin
                // Flush: the word in flight (if any) is dropped and fetch restarts.
                pc_en     = 1'b1;
                pc_src    = 1'b1;
                pc_target = bus.redirect_addr;
                valid_d   = 1'b0;
                instr_d   = NOP_INSTR;
                state_d   = S_ISSUE;
            end else begin
                case (state_q)
                    S_ISSUE: begin
                        imem_rd  = 1'b1;
                        pc_en    = 1'b1;
                        req_pc_d = bus.pc_value;
                        state_d  = S_WAIT;
                    end
                    S_WAIT: begin
                        instr_d    = bus.imem_rdata;
                        instr_pc_d = req_pc_q;
                        valid_d    = 1'b1;
                        state_d    = S_HOLD;
                    end
                    S_HOLD: begin
                        if (bus.instr_ready) begin
                            valid_d = 1'b0;
                            instr_d = NOP_INSTR;
                            state_d = S_ISSUE;
                        end
                    end
                    default: state_d = S_BOOT;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_BOOT;
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    // Request address only matters once ISSUE has written it, so it needs no reset.
    always_ff @(posedge clk) begin
        req_pc_q <= req_pc_d;
    end

    assign bus.pc_en       = pc_en;
    assign bus.pc_src      = pc_src;
    assign bus.pc_target   = pc_target;
    assign bus.imem_rd     = imem_rd;
    assign bus.imem_addr   = imem_addr;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = valid_q;
endmodule

// File: tb/tb_riscv_ifetch.sv
// Directed bench for riscv_ifetch: models the PC register and a synchronous
// instruction memory around the fetch stage and checks each cycle by hand.
module tb_riscv_ifetch;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] W0  = 32'h0050_0093;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mem [256];
    logic [7:0]  pc_reg = 8'h55;

    riscv_ifetch_if #(.ADDR_W(8)) bus ();

    riscv_ifetch #(.ADDR_W(8), .RESET_VEC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // PC register and synchronous instruction memory surrounding the stage
    always @(posedge clk) begin
        if (bus.pc_en)
            pc_reg <= bus.pc_src ? bus.pc_target[7:0] : pc_reg + 8'd1;
        if (bus.imem_rd)
            bus.imem_rdata <= mem[bus.imem_addr];
    end
    assign bus.pc_value = pc_reg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full ISSUE / WAIT / HOLD fetch with the decoder ready.
    task automatic fetch3(input logic [7:0] pc, input logic [31:0] data, input string tag);
        @(negedge clk);
        bus.redirect    = 1'b0;
        bus.instr_ready = 1'b1;
        #1;
        chk({tag, " issue imem_rd"},   32'(bus.imem_rd), 32'd1);
        chk({tag, " issue imem_addr"}, 32'(bus.imem_addr), 32'(pc));
        chk({tag, " issue pc_en"},     32'(bus.pc_en), 32'd1);
        chk({tag, " issue pc_src"},    32'(bus.pc_src), 32'd0);
        chk({tag, " issue valid"},     32'(bus.instr_valid), 32'd0);
        chk({tag, " issue instr"},     bus.instr, NOP);
        @(negedge clk);
        #1;
        chk({tag, " wait pc_en"},      32'(bus.pc_en), 32'd0);
        chk({tag, " wait imem_rd"},    32'(bus.imem_rd), 32'd0);
        chk({tag, " wait valid"},      32'(bus.instr_valid), 32'd0);
        chk({tag, " wait instr"},      bus.instr, NOP);
        @(negedge clk);
        #1;
        chk({tag, " hold valid"},      32'(bus.instr_valid), 32'd1);
        chk({tag, " hold instr_pc"},   32'(bus.instr_pc), 32'(pc));
        chk({tag, " hold instr"},      bus.instr, data);
        chk({tag, " hold pc_en"},      32'(bus.pc_en), 32'd0);
    endtask

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 32'(k) + 32'h100;
        mem[0] = W0;
        rst               = 1'b1;
        bus.instr_ready   = 1'b1;
        bus.redirect      = 1'b0;
        bus.redirect_addr = 32'h0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst pc_en",    32'(bus.pc_en), 32'd0);
        chk("rst pc_src",   32'(bus.pc_src), 32'd0);
        chk("rst imem_rd",  32'(bus.imem_rd), 32'd0);
        chk("rst valid",    32'(bus.instr_valid), 32'd0);
        chk("rst instr",    bus.instr, NOP);
        chk("rst instr_pc", 32'(bus.instr_pc), 32'd0);

        // BOOT cycle with a redirect that must be ignored
        rst               = 1'b0;
        bus.redirect      = 1'b1;
        bus.redirect_addr = 32'h77;
        #1;
        chk("boot pc_en",     32'(bus.pc_en), 32'd1);
        chk("boot pc_src",    32'(bus.pc_src), 32'd1);
        chk("boot pc_target", bus.pc_target, 32'h0);
        chk("boot imem_rd",   32'(bus.imem_rd), 32'd0);

        // First fetch and sequential run
        fetch3(8'h00, W0, "t1");
        for (int k = 1; k <= 3; k++)
            fetch3(8'(k), 32'(k) + 32'h100, $sformatf("t2 pc%0d", k));

        // Backpressure in HOLD
        @(negedge clk);
        bus.instr_ready = 1'b0;
        #1;
        chk("bp issue addr", 32'(bus.imem_addr), 32'h4);
        @(negedge clk);
        #1;
        chk("bp wait pc_en", 32'(bus.pc_en), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chk("bp hold valid",    32'(bus.instr_valid), 32'd1);
            chk("bp hold instr_pc", 32'(bus.instr_pc), 32'h4);
            chk("bp hold instr",    bus.instr, 32'h104);
            chk("bp hold pc_en",    32'(bus.pc_en), 32'd0);
            chk("bp hold imem_rd",  32'(bus.imem_rd), 32'd0);
        end
        @(negedge clk);
        bus.instr_ready = 1'b1;
        #1;
        chk("bp xfer valid", 32'(bus.instr_valid), 32'd1);
        chk("bp xfer pc_en", 32'(bus.pc_en), 32'd0);
        @(negedge clk);
        #1;
        chk("bp after valid", 32'(bus.instr_valid), 32'd0);
        chk("bp after addr",  32'(bus.imem_addr), 32'h5);
        chk("bp after pc_en", 32'(bus.pc_en), 32'd1);

        // Redirect in WAIT: word for pc 5 is discarded
        @(negedge clk);
        bus.redirect      = 1'b1;
        bus.redirect_addr = 32'h40;
        #1;
        chk("rd wait pc_en",     32'(bus.pc_en), 32'd1);
        chk("rd wait pc_src",    32'(bus.pc_src), 32'd1);
        chk("rd wait pc_target", bus.pc_target, 32'h40);
        chk("rd wait imem_rd",   32'(bus.imem_rd), 32'd0);
        fetch3(8'h40, 32'h140, "t4");

        // Redirect in ISSUE to 0xFF, then wrap to 0
        @(negedge clk);
        bus.redirect      = 1'b1;
        bus.redirect_addr = 32'hFF;
        #1;
        chk("rd issue imem_rd",   32'(bus.imem_rd), 32'd0);
        chk("rd issue pc_target", bus.pc_target, 32'hFF);
        fetch3(8'hFF, 32'h1FF, "t5 ff");
        fetch3(8'h00, W0, "t5 wrap");

        // Reset during WAIT
        @(negedge clk);
        #1;
        chk("rw issue addr", 32'(bus.imem_addr), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rw pc_en",     32'(bus.pc_en), 32'd0);
        chk("rw imem_rd",   32'(bus.imem_rd), 32'd0);
        chk("rw imem_addr", 32'(bus.imem_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rw boot valid",     32'(bus.instr_valid), 32'd0);
        chk("rw boot instr",     bus.instr, NOP);
        chk("rw boot pc_src",    32'(bus.pc_src), 32'd1);
        chk("rw boot pc_target", bus.pc_target, 32'h0);
        fetch3(8'h00, W0, "t6 wait");

        // Reset during HOLD
        @(negedge clk);
        bus.instr_ready = 1'b0;
        #1;
        chk("rh issue addr", 32'(bus.imem_addr), 32'h1);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rh hold valid", 32'(bus.instr_valid), 32'd1);
        chk("rh hold instr", bus.instr, 32'h101);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rh pc_en", 32'(bus.pc_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rh boot valid",    32'(bus.instr_valid), 32'd0);
        chk("rh boot instr",    bus.instr, NOP);
        chk("rh boot instr_pc", 32'(bus.instr_pc), 32'd0);
        chk("rh boot pc_en",    32'(bus.pc_en), 32'd1);
        fetch3(8'h00, W0, "t6 hold");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
